// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//   UART receiver. Synchronizes the asynchronous serial line, detects the
//   falling edge of a start bit, samples each bit at mid-period and shifts in
//   DW data bits LSB first, an optional parity bit and one stop bit. Each
//   completed frame is reported with registered one-cycle pulses.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   rx         : serial line, idle high, asynchronous to clk
//   data_out   : last received data word (updated at every stop sample)
//   rx_valid   : 1-cycle pulse, frame received with a good stop bit
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   parity_err : 1-cycle pulse alongside rx_valid/frame_err on parity mismatch
//   busy       : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int CW           = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  output logic [DW-1:0] data_out,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          parity_err,
  output logic          busy
);

  localparam int BW = $clog2(DW + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          perr_q, perr_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          parity_err_q, parity_err_d;
  logic [CW-1:0] limit;
  logic          strobe;

  // The start bit is only checked at its midpoint, so its period is halved;
  // every later strobe then lands in the middle of its bit.
  always_comb begin
    limit  = (state_q == ST_START) ? HALF_LAST : FULL_LAST;
    strobe = (cnt_q == limit);
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    cnt_d        = strobe ? '0 : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A genuine falling edge is required; a line stuck low never starts.
        if (rx_d_q && !rx_s_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (strobe) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
          shreg_d   = {rx_s_q, shreg_q[DW-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DW - 1)) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (strobe) begin
          perr_d  = ((^shreg_q) ^ rx_s_q) != ODD_PAR;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Returning to idle at mid-stop lets a back-to-back start edge be seen.
        if (strobe) begin
          data_out_d   = shreg_q;
          parity_err_d = perr_q;
          rx_valid_d   = rx_s_q;
          frame_err_d  = !rx_s_q;
          perr_d       = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Synchronizer, edge register, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_d_q       <= rx_s_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
